// File: rtl/branch_pc_unit.sv
// PC / redirect stage: computes branch targets, pulses the condition checker enable,
// and redirects or resumes fetch. Optional branch statistics under `BRANCH_STATS_EN`.
module branch_pc_unit #(
  parameter int unsigned         ADDR_W       = 32,
  parameter int unsigned         OFF_W        = 11,
  parameter logic [ADDR_W-1:0]   RESET_PC     = '0,
  parameter int unsigned         FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_uncond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic              br_ok,
  output logic              bcc_not_enable,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              flush,
`ifdef BRANCH_STATS_EN
  output logic              busy,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       not_taken_cnt
`else
  output logic              busy
`endif
);

  typedef enum logic [1:0] {StRun, StEval, StFlush} state_e;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] pc_inc;
  logic              enter_flush;
  logic              not_taken;

  // Halfword offset relative to the branch address plus the 4-byte pipeline lead.
  always_comb begin
    off_ext   = {{(ADDR_W - OFF_W){br_offset[OFF_W-1]}}, br_offset};
    br_target = br_pc + ADDR_W'(4) + (off_ext << 1);
    pc_inc    = pc_q + ADDR_W'(2);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    enter_flush = 1'b0;
    not_taken   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (br_valid) begin
          target_d = br_target;
          if (br_uncond) begin
            pc_d        = br_target;
            cnt_d       = FlushLoad;
            state_d     = StFlush;
            enter_flush = 1'b1;
          end else begin
            state_d = StEval;
          end
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
      StEval: begin
        // Ok is only valid this one cycle, so stall cannot delay the decision.
        if (br_ok) begin
          pc_d        = target_q;
          cnt_d       = FlushLoad;
          state_d     = StFlush;
          enter_flush = 1'b1;
        end else begin
          pc_d      = pc_inc;
          state_d   = StRun;
          not_taken = 1'b1;
        end
      end
      StFlush: begin
        if (cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    pc             = pc_q;
    fetch_valid    = (state_q == StRun) && !rst;
    bcc_not_enable = !((state_q == StRun) && br_valid && !br_uncond && !rst);
    flush          = (state_q == StFlush);
    busy           = (state_q != StRun);
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, not_taken_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q     <= 16'd0;
      not_taken_cnt_q <= 16'd0;
    end else begin
      if (enter_flush && (taken_cnt_q != 16'hFFFF)) begin
        taken_cnt_q <= taken_cnt_q + 16'd1;
      end
      if (not_taken && (not_taken_cnt_q != 16'hFFFF)) begin
        not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
      end
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
`endif

  // Checker enable is a single-cycle pulse; redirect always lands in FLUSH.
  a_enable_pulse: assert property (@(posedge clk) disable iff (rst)
    !bcc_not_enable |=> bcc_not_enable);
  a_flush_entry: assert property (@(posedge clk) disable iff (rst)
    enter_flush |=> flush);
  a_not_taken_resume: assert property (@(posedge clk) disable iff (rst)
    not_taken |=> !busy);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with hand-computed expectations.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        br_uncond;
  logic [31:0] br_pc;
  logic [10:0] br_offset;
  logic        br_ok;
  logic        bcc_not_enable;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        busy;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] not_taken_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_valid       (br_valid),
    .br_uncond      (br_uncond),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .br_ok          (br_ok),
    .bcc_not_enable (bcc_not_enable),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .flush          (flush),
`ifdef BRANCH_STATS_EN
    .busy           (busy),
    .taken_cnt      (taken_cnt),
    .not_taken_cnt  (not_taken_cnt)
`else
    .busy           (busy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_uncond = 1'b0;
    br_pc = '0; br_offset = '0; br_ok = 1'b0;

    // Reset
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv_low", {31'd0, fetch_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_nen", {31'd0, bcc_not_enable}, 32'd1);
`ifdef BRANCH_STATS_EN
    chk("rst_taken", {16'd0, taken_cnt}, 32'd0);
    chk("rst_ntaken", {16'd0, not_taken_cnt}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_fv", {31'd0, fetch_valid}, 32'd1);

    // Sequential fetch 0,2,4,6
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("seq_pc", pc, 32'(2 * i));
      chk("seq_fv", {31'd0, fetch_valid}, 32'd1);
      chk("seq_nen", {31'd0, bcc_not_enable}, 32'd1);
    end

    // Unconditional taken: 0x100 + 4 + 0x20 = 0x124
    br_valid = 1'b1; br_uncond = 1'b1; br_pc = 32'h100; br_offset = 11'h010;
    #1;
    chk("unc_nen", {31'd0, bcc_not_enable}, 32'd1);
    tick();
    // Branch held in FLUSH must be ignored
    br_uncond = 1'b0; br_pc = 32'h200;
    #1;
    chk("unc_pc", pc, 32'h124);
    chk("unc_flush1", {31'd0, flush}, 32'd1);
    chk("unc_fv", {31'd0, fetch_valid}, 32'd0);
    chk("unc_busy", {31'd0, busy}, 32'd1);
    chk("lock_nen", {31'd0, bcc_not_enable}, 32'd1);
    tick();
    chk("unc_flush2", {31'd0, flush}, 32'd1);
    chk("unc_pc2", pc, 32'h124);
    tick();
    br_valid = 1'b0;
    #1;
    chk("unc_run_flush", {31'd0, flush}, 32'd0);
    chk("unc_run_busy", {31'd0, busy}, 32'd0);
    chk("unc_run_pc", pc, 32'h124);
    tick();
    chk("unc_next_pc", pc, 32'h126);

    // Conditional taken: 0x40 + 4 - 4 = 0x40
    br_valid = 1'b1; br_uncond = 1'b0; br_pc = 32'h40; br_offset = 11'h7FE;
    #1;
    chk("ct_nen_low", {31'd0, bcc_not_enable}, 32'd0);
    tick();
    br_valid = 1'b0; br_ok = 1'b1; stall = 1'b1;
    #1;
    chk("ct_eval_nen", {31'd0, bcc_not_enable}, 32'd1);
    chk("ct_eval_busy", {31'd0, busy}, 32'd1);
    chk("ct_eval_fv", {31'd0, fetch_valid}, 32'd0);
    chk("ct_eval_pc", pc, 32'h126);
    tick();
    br_ok = 1'b0; stall = 1'b0;
    chk("ct_pc", pc, 32'h40);
    chk("ct_flush1", {31'd0, flush}, 32'd1);
    tick();
    chk("ct_flush2", {31'd0, flush}, 32'd1);
    tick();
    chk("ct_run_flush", {31'd0, flush}, 32'd0);
    chk("ct_run_pc", pc, 32'h40);

    // Conditional not taken, with a branch presented during EVAL (ignored)
    br_valid = 1'b1; br_uncond = 1'b0; br_pc = 32'h40; br_offset = 11'h7FE;
    #1;
    chk("nt_nen_low", {31'd0, bcc_not_enable}, 32'd0);
    tick();
    br_ok = 1'b0;
    #1;
    chk("nt_eval_busy", {31'd0, busy}, 32'd1);
    chk("nt_eval_nen", {31'd0, bcc_not_enable}, 32'd1);
    tick();
    br_valid = 1'b0;
    #1;
    chk("nt_pc", pc, 32'h42);
    chk("nt_busy", {31'd0, busy}, 32'd0);
    chk("nt_flush", {31'd0, flush}, 32'd0);
    chk("nt_fv", {31'd0, fetch_valid}, 32'd1);

    // Reach 0xFFFFFFFE: 0xFFFFFFF0 + 4 + 0xA
    br_valid = 1'b1; br_uncond = 1'b1; br_pc = 32'hFFFF_FFF0; br_offset = 11'h005;
    tick();
    br_valid = 1'b0;
    tick();
    tick();
    chk("wrap_start_pc", pc, 32'hFFFF_FFFE);
    chk("wrap_start_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("wrap_pc", pc, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'h0);
    end

    // Branch beats stall; target wraps downward: 0 + 4 - 8
    br_valid = 1'b1; br_uncond = 1'b1; br_pc = 32'h0; br_offset = 11'h7FC;
    tick();
    br_valid = 1'b0; stall = 1'b0;
    #1;
    chk("neg_pc", pc, 32'hFFFF_FFFC);
    chk("neg_flush", {31'd0, flush}, 32'd1);
`ifdef BRANCH_STATS_EN
    chk("stat_taken", {16'd0, taken_cnt}, 32'd4);
    chk("stat_ntaken", {16'd0, not_taken_cnt}, 32'd1);
`endif
    tick();
    chk("neg_flush2", {31'd0, flush}, 32'd1);

    // Reset during second flush cycle
    rst = 1'b1;
    tick();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_flush", {31'd0, flush}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("mid_rst_taken", {16'd0, taken_cnt}, 32'd0);
    chk("mid_rst_ntaken", {16'd0, not_taken_cnt}, 32'd0);
`endif
    rst = 1'b0;
    tick();
    chk("after_rst_pc", pc, 32'h2);
    chk("after_rst_fv", {31'd0, fetch_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter and redirect stage directly downstream of the branch condition checker.
- Computes the branch target for each decoded branch and enables the checker for one cycle.
- Consumes the checker's registered Ok one cycle later and either redirects the PC (with a fetch flush) or resumes sequential fetch.
- Sequential step is 2 bytes (16-bit Thumb-style instructions).

Parameters:
- ADDR_W, 32: PC / address width.
- OFF_W, 11: width of the signed branch halfword offset.
- RESET_PC, 0: PC value after reset.
- FLUSH_CYCLES, 2: bubble cycles after a taken branch, legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  fetch back-pressure; holds the PC in RUN.
- br_valid  in  1  decoded branch present this cycle.
- br_uncond  in  1  branch is unconditional (AL); ignores br_ok.
- br_pc  in  ADDR_W  address of the branch instruction.
- br_offset  in  OFF_W  signed halfword offset.
- br_ok  in  1  condition result from the checker (registered Ok, valid one cycle after enable).
- bcc_not_enable  out  1  active-low enable to the checker.
- pc  out  ADDR_W  current fetch address.
- fetch_valid  out  1  pc is a valid fetch this cycle.
- flush  out  1  discard in-flight fetch/decode.
- busy  out  1  state is not RUN.

Behaviour:
- Reset values when rst=1 at an edge: pc=RESET_PC, state=RUN, flush=0, fetch_valid=0 for that cycle then 1, bcc_not_enable=1, busy=0, flush counter=0. Reset overrides every other input in any state.
- Target arithmetic: target = br_pc + 4 + (sign_extend(br_offset) << 1), computed modulo 2^ADDR_W. Wrap-around is silent, in both directions.
- RUN state:
  - fetch_valid=1.
  - stall=1 with no branch: pc holds.
  - stall=0 with no branch: pc <= pc + 2, wrapping at 2^ADDR_W.
  - br_valid=1 and br_uncond=1: latch target; next cycle pc=target; enter FLUSH. Applies even if stall=1 (a branch beats stall).
  - br_valid=1 and br_uncond=0: latch target; drive bcc_not_enable=0 combinationally this cycle; pc holds; enter EVAL.
- EVAL state (exactly one cycle):
  - fetch_valid=0, busy=1, bcc_not_enable=1.
  - br_ok=1: pc <= target, enter FLUSH.
  - br_ok=0: pc <= pc + 2, i.e. the instruction after the branch; return to RUN.
  - stall is ignored here, because Ok is valid for only one cycle.
- FLUSH state:
  - flush=1, fetch_valid=0, busy=1.
  - Counter loads FLUSH_CYCLES-1 on entry and decrements every cycle regardless of stall.
  - At 0, return to RUN; pc holds at target throughout.
- Branch lockout: br_valid is ignored in EVAL and FLUSH. Upstream must re-present the branch, which the flush makes unnecessary.
- Enable pulse: bcc_not_enable is low only in RUN with br_valid=1 and br_uncond=0. It is never low for two consecutive cycles.
- Latency: untaken conditional costs 1 bubble. Taken conditional costs 1 + FLUSH_CYCLES. Unconditional costs FLUSH_CYCLES.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds outputs taken_cnt[15:0] and not_taken_cnt[15:0], both 0 on reset.
  - taken_cnt increments on entry to FLUSH from either RUN or EVAL.
  - not_taken_cnt increments on EVAL with br_ok=0.
  - Both counters saturate at 16'hFFFF.
- When undefined: ports and registers are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then 4 cycles with stall=0, RESET_PC=0 -> pc sequence 0,2,4,6; fetch_valid=1; bcc_not_enable=1 throughout.
- Unconditional taken: br_pc=0x100, br_offset=0x010, br_uncond=1 -> next cycle pc=0x124, flush=1 for 2 cycles, then pc 0x124, 0x126 in RUN.
- Conditional taken: br_pc=0x40, offset=-2 (11'h7FE), br_uncond=0 -> bcc_not_enable=0 for one cycle; br_ok=1 next cycle -> pc=0x40, flush=1 for 2 cycles.
- Conditional not taken: br_pc=0x40, pc=0x40, br_ok=0 in EVAL -> pc=0x42 next cycle, no flush, busy=1 for exactly 1 cycle.
- Wrap and stall: pc=0xFFFFFFFE with stall=0 -> pc=0x00000000. Then stall=1 for 3 cycles -> pc holds at 0.
- Reset mid-FLUSH: rst=1 during the second flush cycle -> next cycle pc=RESET_PC, flush=0, busy=0. With BRANCH_STATS_EN defined, both counters are 0.
